ldst_sequencer: RTL
===================

Name: ldst_sequencer

Overview:
Parametrised control-step sequencer that drives the datapath control lines for the memory-format instructions ld, ldi and st. It replaces hand-driven T0–T7 stimulus with a Moore FSM that fetches, decodes and executes one instruction per pass. It adds a memory ready handshake with wait states, a bus timeout, illegal-opcode trapping and run/stop at instruction boundaries. It sits beside the datapath and connects one-to-one to its control inputs.

Parameters:
OPC_W, 5, opcode width; also the width of ir_opcode and alu_op.
OPC_LD, 5'b00000, ld opcode.
OPC_LDI, 5'b00001, ldi opcode.
OPC_ST, 5'b00010, st opcode.
ALU_ADD, 5'b00001, ALU add code driven on alu_op.
TIMEOUT, 16, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  clock; all state changes on the rising edge.
clr  in  1  synchronous active-low reset.
run  in  1  1 = start or continue fetching; sampled only in IDLE.
ir_opcode  in  OPC_W  IR[31:27]; valid from T3 onward.
mem_ready  in  1  memory completed the current read/write this cycle.
PCout, MARin, incPC, Zin, ZLowOut, PCin, read, write, MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Cout  out  1 each  datapath controls.
alu_op  out  OPC_W  ALU operation code.
busy  out  1  high in every state except IDLE and FAULT.
instr_done  out  1  one-cycle pulse in the last execute cycle.
fault  out  1  high while in FAULT.
step  out  4  encoded current state, for debug.

Behaviour:
- Moore machine: all control outputs decode from the state register only and are held for the whole cycle. Any signal not listed for a state is 0.
- Reset: when clr=0 at a rising edge, state becomes IDLE. All outputs are 0 and alu_op=0. The wait counter clears. Reset mid-instruction aborts the instruction with no further strobes.
- IDLE (step 0): if run=1, go to T0; otherwise stay.
- T0 (step 1): PCout, MARin, incPC, Zin.
- T1 (step 2): ZLowOut, PCin, read, MDRin.
  - Stay in T1 until mem_ready=1, then go to T2.
  - PCin stays asserted during the wait; the datapath reloads the same incremented PC, which is harmless.
- T2 (step 3): MDRout, IRin.
- T3 (step 4): Grb, BAout, Yin.
  - ir_opcode is latched into an internal op register at the end of T3.
  - If the opcode is not ld, ldi or st, go to FAULT instead of T4.
- T4 (step 5): Cout, Zin, alu_op=ALU_ADD.
- T5 (step 6):
  - ldi: ZLowOut, Gra, Rin, instr_done; then go to IDLE.
  - ld/st: ZLowOut, MARin; then go to T6.
- T6 (step 7):
  - ld: read, MDRin; wait for mem_ready.
  - st: Gra, Rout, MDRin; one cycle.
- T7 (step 8):
  - ld: MDRout, Gra, Rin, instr_done; one cycle.
  - st: MDRout, write; wait for mem_ready; instr_done asserts in the cycle where mem_ready=1.
- After T7, go to IDLE.
- Back-to-back instructions: IDLE lasts one cycle if run stays 1. Zero-wait latency, including IDLE:
  - ld and st: 9 cycles.
  - ldi: 7 cycles.
- Wait states:
  - read and write stay high until mem_ready=1.
  - mem_ready is ignored outside the T1, ld-T6 and st-T7 states.
  - mem_ready=1 in the first cycle of a wait state means zero wait.
- Timeout:
  - The wait counter increments in each wait-state cycle with mem_ready=0 and clears on leaving that state.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 in the same cycle as the terminal count wins: the transfer completes, no fault.
- FAULT (step 15): fault=1, all other controls 0. Leaves only via clr=0 to IDLE. run is ignored.
- Dropping run mid-instruction has no effect; the instruction completes and the machine stops in IDLE.
- instr_done and fault are never asserted together.

Test Plan:
- ld r1,0x75(r0) (IR=0x00800075), mem_ready tied 1, memory[0x75]=0xFF00FF00:
  - Steps go 0,1,2,3,4,5,6,7,8,0.
  - R1 ends at 0xFF00FF00.
  - instr_done pulses exactly once, in T7.
- ldi, ir_opcode=OPC_LDI, mem_ready tied 1:
  - Exits to IDLE after T5, with Gra=Rin=ZLowOut=1 in T5.
  - Total 7 cycles; no read is asserted after T1.
- st with mem_ready held low for 3 cycles in T7:
  - write and MDRout stay high for 4 cycles.
  - instr_done is coincident with mem_ready.
- TIMEOUT=4, mem_ready stuck 0 in T1:
  - FAULT is entered after 4 wait cycles; fault=1, read=0.
  - clr=0 for one edge returns to IDLE with all outputs 0.
- ir_opcode=5'b11111 at T3: the next state is FAULT; T4 is never reached, Zin stays 0.
- run=1 held through 3 ld instructions, then clr pulled low during the second one's T6:
  - The next cycle is IDLE with read=0.
  - Restart with run=1 re-fetches from T0.

Source files
------------

// File: rtl/ldst_sequencer.sv
// Control-step sequencer for the memory-format instructions ld, ldi and st.
// It fetches, decodes and executes one instruction per pass. Memory wait states are bounded by a bus timeout.
module ldst_sequencer #(
    parameter int               OPC_W   = 5,
    parameter logic [OPC_W-1:0] OPC_LD  = 5'b00000,
    parameter logic [OPC_W-1:0] OPC_LDI = 5'b00001,
    parameter logic [OPC_W-1:0] OPC_ST  = 5'b00010,
    parameter logic [OPC_W-1:0] ALU_ADD = 5'b00001,
    parameter int               TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             incPC,
    output logic             Zin,
    output logic             ZLowOut,
    output logic             PCin,
    output logic             read,
    output logic             write,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             Yin,
    output logic [OPC_W-1:0] alu_op,
    output logic             busy,
    output logic             instr_done,
    output logic             fault,
    output logic [3:0]       step
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_FAULT = 4'd15
    } state_t;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, rd, wr;
        logic mdr_in, mdr_out, ir_in, gra, grb, r_in, r_out, ba_out, c_out, y_in;
        logic [OPC_W-1:0] alu;
        logic busy, done, st_wait, fault;
    } ctl_t;

    state_t           state, state_n;
    logic [OPC_W-1:0] op, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             wait_st, timeout_hit, op_legal;
    ctl_t             ctl;

    function automatic ctl_t decode(input state_t s, input logic [OPC_W-1:0] o);
        ctl_t c;
        c      = '0;
        c.busy = (s != S_IDLE) && (s != S_FAULT);
        case (s)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            S_T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.rd = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            S_T4: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
            S_T5: begin
                c.zlow_out = 1'b1;
                if (o == OPC_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1; end
                else c.mar_in = 1'b1;
            end
            S_T6: begin
                c.mdr_in = 1'b1;
                if (o == OPC_LD) c.rd = 1'b1;
                else begin c.gra = 1'b1; c.r_out = 1'b1; end
            end
            S_T7: begin
                c.mdr_out = 1'b1;
                if (o == OPC_ST) begin c.wr = 1'b1; c.st_wait = 1'b1; end
                else begin c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1; end
            end
            S_FAULT: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // mem_ready is a completion strobe: a wait state holds its read/write
    // strobe until it samples mem_ready=1 at a rising edge; nothing is sent back.
    always_comb begin
        wait_st     = (state == S_T1) || (state == S_T6 && op == OPC_LD) ||
                      (state == S_T7 && op == OPC_ST);
        timeout_hit = (TIMEOUT > 0) && !mem_ready && (cnt == CNT_LAST);
        op_legal    = (ir_opcode == OPC_LD) || (ir_opcode == OPC_LDI) || (ir_opcode == OPC_ST);
        op_n        = (state == S_T3) ? ir_opcode : op;
        cnt_n       = (wait_st && !mem_ready && !timeout_hit) ? cnt + 1'b1 : '0;
        state_n     = state;
        case (state)
            S_IDLE:  state_n = run ? S_T0 : S_IDLE;
            S_T0:    state_n = S_T1;
            S_T1:    state_n = mem_ready ? S_T2 : (timeout_hit ? S_FAULT : S_T1);
            S_T2:    state_n = S_T3;
            S_T3:    state_n = op_legal ? S_T4 : S_FAULT;
            S_T4:    state_n = S_T5;
            S_T5:    state_n = (op == OPC_LDI) ? S_IDLE : S_T6;
            S_T6: begin
                if (op == OPC_LD) state_n = mem_ready ? S_T7 : (timeout_hit ? S_FAULT : S_T6);
                else              state_n = S_T7;
            end
            S_T7: begin
                if (op == OPC_ST) state_n = mem_ready ? S_IDLE : (timeout_hit ? S_FAULT : S_T7);
                else              state_n = S_IDLE;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_FAULT;
        endcase
    end

    // Outputs are registered from the next state so they match the state register exactly.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= S_IDLE;
            op    <= '0;
            cnt   <= '0;
            ctl   <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            cnt   <= cnt_n;
            ctl   <= decode(state_n, op_n);
        end
    end

    assign {PCout, MARin, incPC, Zin, ZLowOut, PCin, read, write} =
        {ctl.pc_out, ctl.mar_in, ctl.inc_pc, ctl.z_in, ctl.zlow_out, ctl.pc_in, ctl.rd, ctl.wr};
    assign {MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Cout, Yin} =
        {ctl.mdr_in, ctl.mdr_out, ctl.ir_in, ctl.gra, ctl.grb, ctl.r_in, ctl.r_out,
         ctl.ba_out, ctl.c_out, ctl.y_in};
    assign alu_op = ctl.alu;
    assign busy   = ctl.busy;
    assign fault  = ctl.fault;
    assign step   = state;
    // The st write completes in the cycle memory answers, so done follows mem_ready there.
    assign instr_done = ctl.done | (ctl.st_wait & mem_ready);

endmodule
